load_store_unit: RTL
====================

# load_store_unit

Vector load/store execution unit of the VPU, sitting between the `register` read stage and `mem_ctrl` alongside `alu`. It accepts issued unit-stride vector load/store operations (`vle*`/`vse*`) with operands already read, and buffers them in a small in-order FIFO. For each operation it performs one variable-length `mem_ctrl` transaction, then returns a completion on its own writeback port to the writeback arbiter, carrying load data when there is any.

## Interface
- DEPTH, 2: input FIFO entries (power of two, ≥2).
- Widths `XLEN`, `VLEN`, `SB_SIZE_WID`, `OPT_WID`, `FUNCT3_WID`, `REG_WID` from `macros.v`.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- exe_valid  in  1  operation present this cycle; no back-pressure.
- value1  in  `VLEN`  base address in bits [`XLEN`-1:0].
- value2  in  `VLEN`  store data (vs3).
- pos  in  `SB_SIZE_WID`  scoreboard entry tag.
- opt  in  `OPT_WID`  `OPT_LOAD` or `OPT_STORE`; other values ignored.
- funct3  in  `FUNCT3_WID`  EEW: 000=8, 101=16, 110=32, 111=64; others treated as 8.
- rd  in  `REG_WID`  destination vd (loads).
- imm  in  `XLEN`  sign-extended address offset.
- vl  in  `XLEN`  current vl from CSR, sampled at enqueue.
- mc_valid  out  1  memory request.
- mc_we  out  1  1 = store.
- mc_addr  out  `XLEN`  byte address.
- mc_len  out  `XLEN`  byte count.
- mc_src  out  `VLEN`  store data.
- mc_done  in  1  one-cycle completion pulse.
- mc_data  in  `VLEN`  load data, valid in the mc_done cycle.
- wb_valid  out  1  completion available.
- wb_we  out  1  1 = write wb_value to wb_rd.
- wb_pos  out  `SB_SIZE_WID`  tag of completing op.
- wb_rd  out  `REG_WID`  destination register.
- wb_value  out  `VLEN`  load result.
- wb_ready  in  1  arbiter accepts the completion this cycle.
- busy  out  1  FIFO non-empty or FSM not IDLE.
- overflow_err  out  1  sticky; exe_valid arrived while FIFO full.

## Operation
- **Enqueue.** When exe_valid is high and opt is load/store, the unit computes the following at enqueue and stores them with we, src, pos, rd:
  - addr = value1[`XLEN`-1:0] + imm, 32-bit wrap.
  - eb = EEW/8.
  - len = min(vl, `VLEN`/EEW) × eb.
- **Overflow.** An enqueue while the FIFO is full drops the op and sets overflow_err; the scoreboard's LS vacancy guarantees this never happens legally.
- **FSM states:** IDLE, REQ, WB.
- **IDLE:**
  - FIFO non-empty and head len≠0 → REQ, driving mc_* from the head.
  - FIFO non-empty and head len=0 → WB with wb_we=0, no memory access.
- **REQ:**
  - mc_valid and all mc_* outputs are held stable until mc_done.
  - On mc_done the unit captures mc_data and goes to WB. For a load, bytes at index ≥len are forced to 0 (tail zeroed).
- **WB:**
  - wb_valid is held, with wb_* stable, until wb_ready.
  - wb_we=1 only for loads with len≠0.
  - On wb_valid & wb_ready the unit pops the FIFO and returns to IDLE.
- **Ordering:** strictly in order, one memory transaction outstanding.
- **Simultaneous events:** enqueue and pop in the same cycle are both honoured, so count is unchanged and full does not trigger overflow.
- **Spurious mc_done:** mc_done in IDLE or WB is ignored.

## Timing
- **Reset values:** all outputs 0, FIFO empty, FSM IDLE, overflow_err cleared; this takes effect asynchronously, mid-transaction included.
- **Enqueue-to-request:** an op sampled at edge E0 into an empty, idle unit gives mc_valid high after edge E1 (2 cycles from the exe_valid cycle).
- **Completion:** wb_valid rises the cycle after mc_done, and falls the cycle after the wb_ready handshake.
- **Back-to-back:** the next queued op's mc_valid rises the cycle after the pop, giving a minimum of 3 cycles + memory latency per op.
- **Zero-length op:** len=0 gives wb_valid 2 cycles after enqueue.
- **Registered outputs:** all outputs are registered; no combinational path from inputs to outputs.

## Test plan
All scenarios use `VLEN`=128.
- **Load e32.** Load, funct3=110, vl=4, value1=0x100, imm=0x10 → mc_addr=0x110, mc_len=16, mc_we=0. Then mc_done with data D → wb_valid, wb_we=1, wb_value=D, correct pos and rd.
- **Store, vl clamped.** Store, funct3=000, vl=20 → mc_len=16, mc_we=1, mc_src=value2. After mc_done → wb_valid, wb_we=0.
- **Partial load tail.** Load, funct3=101, vl=3 → mc_len=6; mc_data all 0xFF gives wb_value = 0x...FFFFFFFFFFFF in the low 6 bytes, upper 10 bytes 0.
- **Queue and back-pressure.** Three ops back-to-back with DEPTH=2 and wb_ready held low → third op sets overflow_err. The first two complete in order once wb_ready rises.
- **Zero length.** vl=0 → no mc_valid, wb_valid with wb_we=0 two cycles after exe_valid.
- **Reset mid-op.** rst asserted during REQ → mc_valid, busy and wb_valid drop immediately. A later mc_done is ignored and wb_valid stays 0.

Source files
------------

// File: rtl/load_store_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit_if
// Purpose  : Bundles the issue, memory-controller and writeback signals of the
//            vector load/store unit.
//            slave  : the load/store unit itself
//            master : the surrounding pipeline (issue stage, mem_ctrl, arbiter)
// Signals  : exe_valid/value1/value2/pos/opt/funct3/rd/imm/vl  issue side
//            mc_valid/mc_we/mc_addr/mc_len/mc_src/mc_done/mc_data memory side
//            wb_valid/wb_we/wb_pos/wb_rd/wb_value/wb_ready      writeback side
//            busy/overflow_err                                   status
// Revision : 1.0 - initial release
// ============================================================================
interface load_store_unit_if #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned VLEN        = 128,
  parameter int unsigned SB_SIZE_WID = 4,
  parameter int unsigned OPT_WID     = 2,
  parameter int unsigned FUNCT3_WID  = 3,
  parameter int unsigned REG_WID     = 5
) ();

  // Issue side
  logic                   exe_valid;
  logic [VLEN-1:0]        value1;
  logic [VLEN-1:0]        value2;
  logic [SB_SIZE_WID-1:0] pos;
  logic [OPT_WID-1:0]     opt;
  logic [FUNCT3_WID-1:0]  funct3;
  logic [REG_WID-1:0]     rd;
  logic [XLEN-1:0]        imm;
  logic [XLEN-1:0]        vl;

  // Memory controller side
  logic                   mc_valid;
  logic                   mc_we;
  logic [XLEN-1:0]        mc_addr;
  logic [XLEN-1:0]        mc_len;
  logic [VLEN-1:0]        mc_src;
  logic                   mc_done;
  logic [VLEN-1:0]        mc_data;

  // Writeback side
  logic                   wb_valid;
  logic                   wb_we;
  logic [SB_SIZE_WID-1:0] wb_pos;
  logic [REG_WID-1:0]     wb_rd;
  logic [VLEN-1:0]        wb_value;
  logic                   wb_ready;

  // Status
  logic                   busy;
  logic                   overflow_err;

  modport slave (
    input  exe_valid, value1, value2, pos, opt, funct3, rd, imm, vl,
    output mc_valid, mc_we, mc_addr, mc_len, mc_src,
    input  mc_done, mc_data,
    output wb_valid, wb_we, wb_pos, wb_rd, wb_value,
    input  wb_ready,
    output busy, overflow_err
  );

  modport master (
    output exe_valid, value1, value2, pos, opt, funct3, rd, imm, vl,
    input  mc_valid, mc_we, mc_addr, mc_len, mc_src,
    output mc_done, mc_data,
    input  wb_valid, wb_we, wb_pos, wb_rd, wb_value,
    output wb_ready,
    input  busy, overflow_err
  );

endinterface
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit
// Purpose  : Vector unit-stride load/store execution unit. Issued operations
//            are queued in a small in-order FIFO; each one performs a single
//            variable-length mem_ctrl transaction and then presents a
//            completion (with load data) to the writeback arbiter.
// Ports    : clk  - clock, rising edge
//            rst  - asynchronous active-high reset
//            bus  - load_store_unit_if.slave (issue, mem_ctrl, writeback and
//                   status signals; all outputs are registered)
// Revision : 1.0 - initial release
// ============================================================================
module load_store_unit #(
  parameter int unsigned DEPTH       = 2,
  parameter int unsigned XLEN        = 32,
  parameter int unsigned VLEN        = 128,
  parameter int unsigned SB_SIZE_WID = 4,
  parameter int unsigned OPT_WID     = 2,
  parameter int unsigned FUNCT3_WID  = 3,
  parameter int unsigned REG_WID     = 5,
  parameter int unsigned OPT_LOAD    = 1,
  parameter int unsigned OPT_STORE   = 2
) (
  input  logic              clk,
  input  logic              rst,
  load_store_unit_if.slave  bus
);

  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned NBYTES = VLEN / 8;

  typedef struct packed {
    logic                   we;
    logic [XLEN-1:0]        addr;
    logic [XLEN-1:0]        len;
    logic [VLEN-1:0]        src;
    logic [SB_SIZE_WID-1:0] pos;
    logic [REG_WID-1:0]     rd;
  } entry_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WB   = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // Enqueue-side decode: address, element size and byte length
  // --------------------------------------------------------------------------
  logic            is_load;
  logic            is_store;
  logic            enq_req;
  logic [1:0]      eb_log2;
  logic [XLEN-1:0] max_el;
  logic [XLEN-1:0] vl_clamp;
  entry_t          new_entry;
  logic            unused_value1_hi;

  assign is_load  = (bus.opt == OPT_WID'(OPT_LOAD));
  assign is_store = (bus.opt == OPT_WID'(OPT_STORE));
  assign enq_req  = bus.exe_valid && (is_load || is_store);

  // Unrecognised EEW encodings fall back to byte elements.
  always_comb begin
    eb_log2 = 2'd0;
    case (bus.funct3)
      FUNCT3_WID'(5): eb_log2 = 2'd1;
      FUNCT3_WID'(6): eb_log2 = 2'd2;
      FUNCT3_WID'(7): eb_log2 = 2'd3;
      default:        eb_log2 = 2'd0;
    endcase
  end

  // Elements per register = VLEN/EEW; vl beyond that is clamped.
  assign max_el   = XLEN'(NBYTES) >> eb_log2;
  assign vl_clamp = (bus.vl < max_el) ? bus.vl : max_el;

  always_comb begin
    new_entry      = '0;
    new_entry.we   = is_store;
    new_entry.addr = bus.value1[XLEN-1:0] + bus.imm;
    new_entry.len  = vl_clamp << eb_log2;
    new_entry.src  = bus.value2;
    new_entry.pos  = bus.pos;
    new_entry.rd   = bus.rd;
  end

  // Only the low XLEN bits of value1 carry the base address.
  assign unused_value1_hi = ^bus.value1[VLEN-1:XLEN];

  // --------------------------------------------------------------------------
  // In-order FIFO
  // --------------------------------------------------------------------------
  entry_t            fifo_mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  count_d;
  logic              fifo_full;
  logic              enq;
  logic              pop;
  entry_t            head;

  assign head      = fifo_mem[rd_ptr_q];
  assign fifo_full = (count_q == CNT_W'(DEPTH));
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign enq       = enq_req && (!fifo_full || pop);
  assign count_d   = count_q + CNT_W'(enq) - CNT_W'(pop);

  always_ff @(posedge clk) begin
    if (enq) begin
      fifo_mem[wr_ptr_q] <= new_entry;
    end
  end

  // --------------------------------------------------------------------------
  // Load tail mask: bytes at index >= len are forced to zero
  // --------------------------------------------------------------------------
  logic [VLEN-1:0] tail_mask;

  for (genvar b = 0; b < NBYTES; b++) begin : g_tail_mask
    assign tail_mask[b*8 +: 8] = (XLEN'(b) < head.len) ? 8'hFF : 8'h00;
  end

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------
  state_t                 state_q;
  state_t                 state_d;
  logic                   mc_valid_q,  mc_valid_d;
  logic                   mc_we_q,     mc_we_d;
  logic [XLEN-1:0]        mc_addr_q,   mc_addr_d;
  logic [XLEN-1:0]        mc_len_q,    mc_len_d;
  logic [VLEN-1:0]        mc_src_q,    mc_src_d;
  logic                   wb_valid_q,  wb_valid_d;
  logic                   wb_we_q,     wb_we_d;
  logic [SB_SIZE_WID-1:0] wb_pos_q,    wb_pos_d;
  logic [REG_WID-1:0]     wb_rd_q,     wb_rd_d;
  logic [VLEN-1:0]        wb_value_q,  wb_value_d;
  logic                   busy_q,      busy_d;
  logic                   overflow_q,  overflow_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    mc_valid_d = mc_valid_q;
    mc_we_d    = mc_we_q;
    mc_addr_d  = mc_addr_q;
    mc_len_d   = mc_len_q;
    mc_src_d   = mc_src_q;
    wb_valid_d = wb_valid_q;
    wb_we_d    = wb_we_q;
    wb_pos_d   = wb_pos_q;
    wb_rd_d    = wb_rd_q;
    wb_value_d = wb_value_q;
    pop        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          wb_pos_d = head.pos;
          wb_rd_d  = head.rd;
          if (head.len != '0) begin
            state_d    = S_REQ;
            mc_valid_d = 1'b1;
            mc_we_d    = head.we;
            mc_addr_d  = head.addr;
            mc_len_d   = head.len;
            mc_src_d   = head.src;
          end else begin
            // Zero-length op completes without touching memory.
            state_d    = S_WB;
            wb_valid_d = 1'b1;
            wb_we_d    = 1'b0;
            wb_value_d = '0;
          end
        end
      end

      S_REQ: begin
        if (bus.mc_done) begin
          state_d    = S_WB;
          mc_valid_d = 1'b0;
          wb_valid_d = 1'b1;
          wb_we_d    = !head.we;
          wb_value_d = head.we ? bus.mc_data : (bus.mc_data & tail_mask);
        end
      end

      S_WB: begin
        if (bus.wb_ready) begin
          state_d    = S_IDLE;
          wb_valid_d = 1'b0;
          wb_we_d    = 1'b0;
          pop        = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy_d     = (count_d != '0) || (state_d != S_IDLE);
  assign overflow_d = overflow_q || (enq_req && fifo_full && !pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      mc_valid_q <= 1'b0;
      mc_we_q    <= 1'b0;
      mc_addr_q  <= '0;
      mc_len_q   <= '0;
      mc_src_q   <= '0;
      wb_valid_q <= 1'b0;
      wb_we_q    <= 1'b0;
      wb_pos_q   <= '0;
      wb_rd_q    <= '0;
      wb_value_q <= '0;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (enq) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      count_q    <= count_d;
      mc_valid_q <= mc_valid_d;
      mc_we_q    <= mc_we_d;
      mc_addr_q  <= mc_addr_d;
      mc_len_q   <= mc_len_d;
      mc_src_q   <= mc_src_d;
      wb_valid_q <= wb_valid_d;
      wb_we_q    <= wb_we_d;
      wb_pos_q   <= wb_pos_d;
      wb_rd_q    <= wb_rd_d;
      wb_value_q <= wb_value_d;
      busy_q     <= busy_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.mc_valid     = mc_valid_q;
  assign bus.mc_we        = mc_we_q;
  assign bus.mc_addr      = mc_addr_q;
  assign bus.mc_len       = mc_len_q;
  assign bus.mc_src       = mc_src_q;
  assign bus.wb_valid     = wb_valid_q;
  assign bus.wb_we        = wb_we_q;
  assign bus.wb_pos       = wb_pos_q;
  assign bus.wb_rd        = wb_rd_q;
  assign bus.wb_value     = wb_value_q;
  assign bus.busy         = busy_q;
  assign bus.overflow_err = overflow_q;

endmodule
`default_nettype wire
